// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_pkg
//  Purpose  : Shared types and constants for the mem_copy_engine mini-DMA.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_copy_pkg;

    // Copy engine sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bytes per memory word; pointers advance by this amount
    localparam int unsigned WORD_BYTES      = 4;

    // Low byte-address bits that are dropped to force word alignment
    localparam int unsigned ADDR_ALIGN_MASK = WORD_BYTES - 1;

endpackage : mem_copy_pkg
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_engine
//  Purpose  : Mini-DMA that copies LEN consecutive words from a source to a
//             destination address over a single-port word memory interface,
//             one word every two cycles (READ then WRITE).
//  Options  : MEM_COPY_CHECKSUM_EN adds a running sum of all words read.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] c_align_keep = ~ADDR_W'(ADDR_ALIGN_MASK);
    localparam logic [ADDR_W-1:0] c_step       = ADDR_W'(WORD_BYTES);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_src_ptr;
    logic [ADDR_W-1:0]   r_dst_ptr;
    logic [LEN_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_buffer;

    logic [ADDR_W-1:0]   w_src_aligned;
    logic [ADDR_W-1:0]   w_dst_aligned;

    assign w_src_aligned  = src_addr & c_align_keep;
    assign w_dst_aligned  = dst_addr & c_align_keep;

    // The buffer register drives write data directly, so it is glitch-free
    assign mem_write_data = r_buffer;

    // Sequencer: outputs are computed for the state being entered so that
    // every memory-side signal comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_count     <= '0;
            r_buffer    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src_ptr <= w_src_aligned;
                        r_dst_ptr <= w_dst_aligned;
                        r_count   <= len;
                        if (len != '0) begin
                            r_state     <= READ;
                            busy        <= 1'b1;
                            mem_address <= w_src_aligned;
                        end else begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_buffer    <= mem_read_data;
                    r_src_ptr   <= r_src_ptr + c_step;
                    r_state     <= WRITE;
                    mem_address <= r_dst_ptr;
                    mem_write   <= 1'b1;
                end
                WRITE: begin
                    r_dst_ptr <= r_dst_ptr + c_step;
                    r_count   <= r_count - LEN_W'(1);
                    mem_write <= 1'b0;
                    if (r_count == LEN_W'(1)) begin
                        r_state     <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        mem_address <= '0;
                    end else begin
                        // r_src_ptr was already advanced in READ
                        r_state     <= READ;
                        mem_address <= r_src_ptr;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    busy        <= 1'b0;
                    mem_write   <= 1'b0;
                    mem_address <= '0;
                end
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    // Running sum of every word read; cleared when a new transfer is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (r_state == IDLE && start) begin
            checksum <= '0;
        end else if (r_state == READ) begin
            checksum <= checksum + mem_read_data;
        end
    end
`endif

endmodule : mem_copy_engine
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_copy_engine
//  Purpose  : Self-checking bench for mem_copy_engine with a behavioural
//             word memory, a reference copy model and read/write scoreboards.
//  Options  : MEM_COPY_CHECKSUM_EN enables the checksum port checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    // Bench memory (4 KB, aliased on address bits [11:2]) and its reference
    logic [31:0] mem       [0:1023];
    logic [31:0] model_mem [0:1023];
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    // Expected traffic: write {address,data} and read addresses
    logic [63:0] wr_q [$];
    logic [31:0] rd_q [$];

    int busy_cnt;
    int wr_cnt;
    int done_cnt;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    // Single-port memory: async read, posedge write (bench loader has priority)
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr[11:2]] <= ld_data;
        else if (mem_write)
            mem[mem_address[11:2]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[11:2]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=unexpected-event expected=none", tag);
    endtask

    // Monitor: sample away from the active edge and score memory traffic
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (mem_write) begin
                wr_cnt++;
                check("write_while_busy", busy, 1'b1);
                if (wr_q.size() == 0) fail_now("unexpected_write");
                else check("write_addr_data", {mem_address, mem_write_data}, wr_q.pop_front());
            end else if (busy) begin
                if (rd_q.size() == 0) fail_now("unexpected_read");
                else check("read_addr", mem_address, rd_q.pop_front());
            end else begin
                check("idle_outputs", {mem_write, mem_address}, 33'd0);
            end
            if (busy && done) fail_now("busy_with_done");
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
        model_mem[a[11:2]] = d;
    endtask

    // Reference model: ascending word copy, reads then writes per word
    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n,
                        input int nrd, input int nwr, output logic [31:0] sum);
        logic [31:0] sp, dp, v;
        sp  = s & 32'hFFFF_FFFC;
        dp  = d & 32'hFFFF_FFFC;
        sum = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (i < nrd) begin
                rd_q.push_back(sp);
                v = model_mem[sp[11:2]];
                sum = sum + v;
                if (i < nwr) begin
                    model_mem[dp[11:2]] = v;
                    wr_q.push_back({dp, v});
                end
            end
            sp = sp + 32'd4;
            dp = dp + 32'd4;
        end
    endtask

    // Launch one transfer; returns edges after the start edge until done
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input bit poke, output int done_edge);
        @(negedge clk);
        #1;
        busy_cnt = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        done_edge = -1;
        for (int k = 0; k < 300; k++) begin
            if (poke && k == 3) start = 1'b1;
            if (poke && k == 5) start = 1'b0;
            if (done) begin
                done_edge = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          de;
        logic [31:0] sum;

        rst_n    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;

        for (int i = 0; i < 1024; i++) load(32'(i * 4), 32'd0);
        check("rst_busy",       busy,           1'b0);
        check("rst_done",       done,           1'b0);
        check("rst_mem_write",  mem_write,      1'b0);
        check("rst_mem_addr",   mem_address,    32'd0);
        check("rst_write_data", mem_write_data, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check("rst_checksum",   checksum,       32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic copy of four words
        load(32'h100, 32'd11); load(32'h104, 32'd22);
        load(32'h108, 32'd33); load(32'h10C, 32'd44);
        plan(32'h100, 32'h200, 4, 4, 4, sum);
        run(32'h100, 32'h200, 16'd4, 1'b0, de);
        check("basic_done_cycle", de + 2,  32'd10);
        check("basic_busy_cycles", busy_cnt, 32'd8);
        check("basic_write_cycles", wr_cnt, 32'd4);
        check("basic_done_pulses", done_cnt, 32'd1);
        check("basic_mem0", mem[32'h200 >> 2], 32'd11);
        check("basic_mem1", mem[32'h204 >> 2], 32'd22);
        check("basic_mem2", mem[32'h208 >> 2], 32'd33);
        check("basic_mem3", mem[32'h20C >> 2], 32'd44);

        // Zero length: done on the cycle after the start edge, no traffic
        run(32'h40, 32'h80, 16'd0, 1'b0, de);
        check("zero_done_cycle",  de + 2,   32'd2);
        check("zero_busy_cycles", busy_cnt, 32'd0);
        check("zero_write_cycles", wr_cnt,  32'd0);
        check("zero_done_pulses", done_cnt, 32'd1);

        // Misaligned source that wraps past the top of the address space
        load(32'hFFFF_FFFC, 32'hCAFE_0001);
        load(32'h0000_0000, 32'hCAFE_0002);
        plan(32'hFFFF_FFFE, 32'h300, 2, 2, 2, sum);
        run(32'hFFFF_FFFE, 32'h300, 16'd2, 1'b0, de);
        check("wrap_done_cycle", de + 2, 32'd6);
        check("wrap_write_cycles", wr_cnt, 32'd2);
        check("wrap_mem0", mem[32'h300 >> 2], 32'hCAFE_0001);
        check("wrap_mem1", mem[32'h304 >> 2], 32'hCAFE_0002);

        // Overlapping forward copy with a start pulse mid-transfer
        load(32'h0, 32'hA); load(32'h4, 32'hB);
        load(32'h8, 32'hC); load(32'hC, 32'hD);
        plan(32'h0, 32'h4, 3, 3, 3, sum);
        run(32'h0, 32'h4, 16'd3, 1'b1, de);
        check("ovl_done_cycle", de + 2, 32'd8);
        check("ovl_write_cycles", wr_cnt, 32'd3);
        check("ovl_done_pulses", done_cnt, 32'd1);
        check("ovl_idle_after", busy, 1'b0);
        check("ovl_mem1", mem[1], 32'hA);
        check("ovl_mem2", mem[2], 32'hA);
        check("ovl_mem3", mem[3], 32'hA);

        // Reset abort during the WRITE of word 2
        load(32'h600, 32'h61); load(32'h604, 32'h62);
        load(32'h608, 32'h63); load(32'h60C, 32'h64);
        plan(32'h600, 32'h700, 4, 2, 1, sum);
        @(negedge clk);
        #1;
        busy_cnt = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        src_addr = 32'h600;
        dst_addr = 32'h700;
        len      = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_in_write2", {mem_write, mem_address}, {1'b1, 32'h704});
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_mem_write", mem_write,   1'b0);
        check("abort_busy",      busy,        1'b0);
        check("abort_mem_addr",  mem_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done",    done_cnt, 32'd0);
        check("abort_writes",     wr_cnt,   32'd1);
        check("abort_busy_after", busy,     1'b0);
        check("abort_mem0", mem[32'h700 >> 2], 32'h61);
        check("abort_mem1", mem[32'h704 >> 2], 32'h0);

        // Checksum wraps modulo 2^32
        load(32'h400, 32'd1); load(32'h404, 32'd2);
        load(32'h408, 32'd3); load(32'h40C, 32'hFFFF_FFFF);
        plan(32'h400, 32'h500, 4, 4, 4, sum);
        run(32'h400, 32'h500, 16'd4, 1'b0, de);
        check("cks_done_cycle", de + 2, 32'd10);
        check("cks_mem3", mem[32'h50C >> 2], 32'hFFFF_FFFF);
`ifdef MEM_COPY_CHECKSUM_EN
        check("cks_value", checksum, 32'h0000_0005);
        check("cks_model", checksum, sum);
        repeat (4) @(posedge clk);
        #1;
        check("cks_hold", checksum, 32'h0000_0005);
`endif

        check("wr_q_drained", wr_q.size(), 32'd0);
        check("rd_q_drained", rd_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_copy_engine
`default_nettype wire
